// File: rtl/board_pkg.sv
// Shared constants and traverser state encoding for the Game-of-Life board.
package board_pkg;

    localparam int BOARD_COLS = 80;
    localparam int BOARD_ROWS = 60;
    localparam int ADDR_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } trav_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up counter: counts 0..MAX-1, wraps to 0 on increment at MAX-1.
module wrap_counter #(
    parameter int MAX = 4,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         at_max
);

    assign at_max = (value == W'(MAX - 1));

    // Clear wins over increment so the idle states pin the address at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc)
            value <= at_max ? '0 : value + W'(1);
    end

endmodule

// File: rtl/travers_board_m.sv
// Raster-scan (row-major, column fastest) cell address generator with a one-sweep-per-enable FSM.
module travers_board_m
    import board_pkg::*;
#(
    parameter int COLS = BOARD_COLS,
    parameter int ROWS = BOARD_ROWS,
    parameter int AW   = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [AW-1:0] addrC,
    output logic [AW-1:0] addrR,
    output logic          finish
);

    trav_state_t state, nxt;
    logic col_max, row_max, scan_step, last_cell, clr;

    assign scan_step = (state == SCAN) && enable;
    assign last_cell = col_max && row_max;
    assign clr       = (state != SCAN);

    // Both counters wrap to zero on the last cell, so no explicit clear is needed there.
    wrap_counter #(.MAX(COLS), .W(AW)) u_col (
        .clk    (clk),
        .rst    (rst),
        .inc    (scan_step),
        .clr    (clr),
        .value  (addrC),
        .at_max (col_max)
    );

    wrap_counter #(.MAX(ROWS), .W(AW)) u_row (
        .clk    (clk),
        .rst    (rst),
        .inc    (scan_step && col_max),
        .clr    (clr),
        .value  (addrR),
        .at_max (row_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            finish <= 1'b0;
        end else begin
            state  <= nxt;
            finish <= scan_step && last_cell;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (enable) nxt = SCAN;
            SCAN: if (enable && last_cell) nxt = DONE;
            DONE: nxt = enable ? HOLD : IDLE;
            HOLD: if (!enable) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_travers_board_m.sv
// Directed bench for travers_board_m: 4x3 board plus degenerate 1x1 and 1x3 boards.
module tb_travers_board_m;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       en1;
    logic [7:0] addr_c, addr_r;
    logic       fin;
    logic [7:0] d_c, d_r, c1_c, c1_r;
    logic       d_fin, c1_fin;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    travers_board_m #(.COLS(4), .ROWS(3), .AW(8)) dut (
        .clk(clk), .rst(rst), .enable(en), .addrC(addr_c), .addrR(addr_r), .finish(fin)
    );

    travers_board_m #(.COLS(1), .ROWS(1), .AW(8)) u_deg (
        .clk(clk), .rst(rst), .enable(en1), .addrC(d_c), .addrR(d_r), .finish(d_fin)
    );

    travers_board_m #(.COLS(1), .ROWS(3), .AW(8)) u_col1 (
        .clk(clk), .rst(rst), .enable(en1), .addrC(c1_c), .addrR(c1_r), .finish(c1_fin)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cell(input string tag, input int r, input int c, input int f);
        chk({tag, ".row"}, int'(addr_r), r);
        chk({tag, ".col"}, int'(addr_c), c);
        chk({tag, ".fin"}, int'(fin), f);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks cells first..11 (one edge each) and the finishing edge, enable held high.
    task automatic sweep_from(input string tag, input int first);
        for (int k = first; k < 12; k++) begin
            step();
            chk_cell(tag, k / 4, k % 4, 0);
        end
        step();
        chk_cell({tag, ".finish"}, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        en1 = 1'b0;
        #2;
        chk_cell("reset", 0, 0, 0);
        step();
        rst = 1'b0;

        // Idle with enable low
        for (int i = 0; i < 10; i++) begin
            step();
            chk_cell("idle", 0, 0, 0);
        end

        // Full sweep, then enable held high: HOLD, no second pulse
        en = 1'b1;
        sweep_from("sweep1", 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_cell("hold", 0, 0, 0);
        end
        en = 1'b0;
        step();
        chk_cell("hold_exit", 0, 0, 0);

        // Sweep with a 5-cycle pause at (1,2)
        en = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step();
            chk_cell("pre_pause", k / 4, k % 4, 0);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_cell("pause", 1, 2, 0);
        end
        en = 1'b1;
        sweep_from("resume", 7);

        // Re-arm directly from DONE: one low cycle then a full second sweep
        en = 1'b0;
        step();
        chk_cell("rearm_idle", 0, 0, 0);
        en = 1'b1;
        sweep_from("sweep3", 0);
        en = 1'b0;
        step();
        step();

        // Reset asserted between edges while presenting (2,1)
        en = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            step();
            chk_cell("pre_rst", k / 4, k % 4, 0);
        end
        #2;
        rst = 1'b1;
        #1;
        chk_cell("async_rst", 0, 0, 0);
        step();
        chk_cell("rst_held", 0, 0, 0);
        en  = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cell("post_rst", 0, 0, 0);
        end
        en = 1'b1;
        step();
        chk_cell("restart0", 0, 0, 0);
        step();
        chk_cell("restart1", 0, 1, 0);
        en = 1'b0;
        step();
        step();

        // Degenerate boards: 1x1 and a single-column 3-row board
        en1 = 1'b1;
        step();
        chk("deg.e1.fin", int'(d_fin), 0);
        chk("deg.e1.addr", int'({d_r, d_c}), 0);
        chk("col1.e1.row", int'(c1_r), 0);
        step();
        chk("deg.e2.fin", int'(d_fin), 1);
        chk("deg.e2.addr", int'({d_r, d_c}), 0);
        chk("col1.e2.row", int'(c1_r), 1);
        chk("col1.e2.col", int'(c1_c), 0);
        step();
        chk("deg.e3.fin", int'(d_fin), 0);
        chk("col1.e3.row", int'(c1_r), 2);
        chk("col1.e3.fin", int'(c1_fin), 0);
        step();
        chk("col1.e4.fin", int'(c1_fin), 1);
        chk("col1.e4.row", int'(c1_r), 0);
        chk("deg.e4.fin", int'(d_fin), 0);
        en1 = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
